// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm
// Multicycle control-unit state machine for the OTTER RV32I core.
// Sequences each instruction through FETCH, EXEC and (for loads) WB,
// takes at most one external interrupt per instruction boundary, and
// parks in HALT with a sticky FAULT if memory fails to answer in time.
//
// Ports:
//   CLK        system clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   OPCODE     IR[6:0] of the current instruction
//   FUNCT3     IR[14:12]
//   INTR       level interrupt request
//   MIE        mstatus.MIE, interrupts are taken only when 1
//   MEM_VALID  memory has returned data for the outstanding read
//   PC_WE      PC load enable
//   RF_WE      register-file write enable
//   MEM_WE2    data-port store strobe
//   MEM_RDEN1  instruction-port read enable
//   MEM_RDEN2  data-port read enable
//   CSR_WE     CSR write enable
//   INT_TAKEN  interrupt entry (mtvec select, mepc save)
//   RST_OUT    reset to PC and register file
//   FAULT      sticky memory-timeout flag, cleared only by RST
module otter_cu_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       INTR,
  input  logic       MIE,
  input  logic       MEM_VALID,
  output logic       PC_WE,
  output logic       RF_WE,
  output logic       MEM_WE2,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       RST_OUT,
  output logic       FAULT
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR,
    ST_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  logic is_load;
  logic mem_wait;
  logic timeout;
  logic boundary;
  logic take_intr;

  assign is_load  = (OPCODE == OPC_LOAD);
  // A wait cycle is any FETCH/WB cycle without returned data.
  assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_WB)) && !MEM_VALID;
  // Fires on the wait cycle that brings the count up to MEM_TIMEOUT; a
  // MEM_VALID in that same cycle clears mem_wait, so data beats the fault.
  assign timeout  = mem_wait && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign boundary = ((state_q == ST_EXEC) && !is_load) ||
                    ((state_q == ST_WB) && MEM_VALID);
  assign take_intr = boundary && INTR && MIE;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    // Counter is zero whenever a wait state is entered, since every
    // non-waiting cycle clears it.
    wait_cnt_d = mem_wait ? (wait_cnt_q + 1'b1) : '0;
    fault_d    = fault_q | timeout;
    case (state_q)
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (MEM_VALID)    state_d = ST_EXEC;
        else if (timeout) state_d = ST_HALT;
      end
      ST_EXEC: begin
        if (is_load)        state_d = ST_WB;
        else if (take_intr) state_d = ST_INTR;
        else                state_d = ST_FETCH;
      end
      ST_WB: begin
        if (MEM_VALID)    state_d = take_intr ? ST_INTR : ST_FETCH;
        else if (timeout) state_d = ST_HALT;
      end
      ST_INTR:  state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    RST_OUT   = 1'b0;
    case (state_q)
      ST_INIT:  RST_OUT   = 1'b1;
      ST_FETCH: MEM_RDEN1 = 1'b1;
      ST_EXEC: begin
        case (OPCODE)
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            PC_WE = 1'b1;
            RF_WE = 1'b1;
          end
          OPC_BRANCH: PC_WE = 1'b1;
          OPC_STORE: begin
            PC_WE   = 1'b1;
            MEM_WE2 = 1'b1;
          end
          OPC_LOAD: MEM_RDEN2 = 1'b1;
          OPC_SYSTEM: begin
            PC_WE = 1'b1;
            // ecall/mret (FUNCT3=000) only advance the PC.
            if (FUNCT3 != 3'b000) begin
              RF_WE  = 1'b1;
              CSR_WE = 1'b1;
            end
          end
          default: PC_WE = 1'b1;
        endcase
      end
      ST_WB: begin
        MEM_RDEN2 = 1'b1;
        if (MEM_VALID) begin
          RF_WE = 1'b1;
          PC_WE = 1'b1;
        end
      end
      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WE     = 1'b1;
      end
      default: ;
    endcase
  end

  assign FAULT = fault_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm
// Builds a cycle-by-cycle plan of whole instructions (fetch waits, exec,
// load writeback waits, interrupt entry, timeouts, resets), deriving the
// expected strobes for each cycle from the instruction-level rules, then
// replays the plan into otter_cu_fsm and compares every cycle.
module tb_otter_cu_fsm;

  localparam int MT = 15;

  localparam logic [8:0] E_PC  = 9'h001;
  localparam logic [8:0] E_RF  = 9'h002;
  localparam logic [8:0] E_WE2 = 9'h004;
  localparam logic [8:0] E_RD1 = 9'h008;
  localparam logic [8:0] E_RD2 = 9'h010;
  localparam logic [8:0] E_CSR = 9'h020;
  localparam logic [8:0] E_INT = 9'h040;
  localparam logic [8:0] E_RO  = 9'h080;
  localparam logic [8:0] E_FT  = 9'h100;

  localparam logic [6:0] LOAD = 7'b0000011;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       INTR, MIE, MEM_VALID;
  logic       PC_WE, RF_WE, MEM_WE2, MEM_RDEN1, MEM_RDEN2;
  logic       CSR_WE, INT_TAKEN, RST_OUT, FAULT;

  otter_cu_fsm #(.MEM_TIMEOUT(MT)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .INTR(INTR), .MIE(MIE), .MEM_VALID(MEM_VALID),
    .PC_WE(PC_WE), .RF_WE(RF_WE), .MEM_WE2(MEM_WE2),
    .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .CSR_WE(CSR_WE),
    .INT_TAKEN(INT_TAKEN), .RST_OUT(RST_OUT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       intr;
    logic       mie;
    logic       vld;
    logic [8:0] exp;
    string      tag;
  } step_t;

  step_t trace[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %03h expected %03h", tag, $time, got, exp);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected EXEC strobes straight from the opcode table.
  function automatic logic [8:0] exec_exp(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0010011, 7'b0110011: return E_PC | E_RF;
      7'b1100011:             return E_PC;
      7'b0100011:             return E_PC | E_WE2;
      7'b0000011:             return E_RD2;
      7'b1110011:             return (f3 != 3'b000) ? (E_PC | E_RF | E_CSR) : E_PC;
      default:                return E_PC;
    endcase
  endfunction

  function automatic logic [6:0] pick_opc(input int i);
    case (i)
      0: return 7'b0110111;
      1: return 7'b0010111;
      2: return 7'b1101111;
      3: return 7'b1100111;
      4: return 7'b0010011;
      5: return 7'b0110011;
      6: return 7'b1100011;
      7: return 7'b0100011;
      8: return 7'b0000011;
      9: return 7'b1110011;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return MT;
    if (r == 1) return MT - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic push(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                      input logic intr, input logic mie, input logic vld,
                      input logic [8:0] exp, input string tag);
    step_t s;
    s.rst = rst; s.opc = opc; s.f3 = f3; s.intr = intr; s.mie = mie;
    s.vld = vld; s.exp = exp; s.tag = tag;
    trace.push_back(s);
  endtask

  task automatic push_init();
    push(1'b0, 7'($urandom), 3'($urandom), rb(), rb(), rb(), E_RO, "init");
  endtask

  // Stuck in HALT until reset; reset then lands in INIT with FAULT cleared.
  task automatic halt_seq();
    for (int i = 0; i < 3; i++)
      push(1'b0, 7'($urandom), 3'($urandom), rb(), rb(), rb(), E_FT, "halt");
    push(1'b1, 7'($urandom), 3'($urandom), rb(), rb(), rb(), E_FT, "halt_rst");
    push_init();
  endtask

  task automatic gen_instr(input logic [6:0] opc, input logic [2:0] f3,
                           input int w1, input int w2,
                           input logic ib, input logic mb, input logic abort_wb);
    for (int i = 0; i < w1 && i < MT; i++)
      push(1'b0, opc, f3, rb(), rb(), 1'b0, E_RD1, "fetch_wait");
    if (w1 >= MT) begin
      halt_seq();
      return;
    end
    push(1'b0, opc, f3, rb(), rb(), 1'b1, E_RD1, "fetch");
    if (opc != LOAD) begin
      push(1'b0, opc, f3, ib, mb, rb(), exec_exp(opc, f3), "exec");
      if (ib && mb) push(1'b0, opc, f3, rb(), rb(), rb(), E_INT | E_PC, "intr");
      return;
    end
    push(1'b0, opc, f3, rb(), rb(), rb(), E_RD2, "exec_ld");
    if (abort_wb) begin
      for (int i = 0; i < w2 && i < MT - 2; i++)
        push(1'b0, opc, f3, rb(), rb(), 1'b0, E_RD2, "wb_wait");
      push(1'b1, opc, f3, rb(), rb(), 1'b0, E_RD2, "wb_rst");
      push_init();
      return;
    end
    for (int i = 0; i < w2 && i < MT; i++)
      push(1'b0, opc, f3, rb(), rb(), 1'b0, E_RD2, "wb_wait");
    if (w2 >= MT) begin
      halt_seq();
      return;
    end
    push(1'b0, opc, f3, ib, mb, 1'b1, E_RD2 | E_RF | E_PC, "wb");
    if (ib && mb) push(1'b0, opc, f3, rb(), rb(), rb(), E_INT | E_PC, "intr");
  endtask

  initial begin
    RST = 1'b1; OPCODE = '0; FUNCT3 = '0; INTR = 1'b0; MIE = 1'b0; MEM_VALID = 1'b0;

    // Reset held for two checked cycles, then release into INIT.
    push(1'b1, 7'b0010011, 3'd0, 1'b1, 1'b1, 1'b1, E_RO, "reset");
    push(1'b0, 7'b0010011, 3'd0, 1'b0, 1'b0, 1'b1, E_RO, "init");
    // Directed scenarios.
    gen_instr(7'b0010011, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);   // ADDI
    gen_instr(7'b0010011, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);   // ADDI back to back
    gen_instr(7'b0000011, 3'd2, 0, 3, 1'b0, 1'b0, 1'b0);   // LW, 3 WB waits
    gen_instr(7'b0100011, 3'd2, 1, 0, 1'b0, 1'b0, 1'b0);   // SW
    gen_instr(7'b1100011, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);   // BRANCH
    gen_instr(7'b0110011, 3'd6, 0, 0, 1'b1, 1'b1, 1'b0);   // OR, interrupt taken
    gen_instr(7'b0110011, 3'd6, 0, 0, 1'b1, 1'b0, 1'b0);   // OR, MIE=0
    gen_instr(7'b0000011, 3'd2, 0, 1, 1'b1, 1'b1, 1'b0);   // LW, interrupt at WB
    gen_instr(7'b1110011, 3'd1, 0, 0, 1'b0, 1'b0, 1'b0);   // CSRRW
    gen_instr(7'b1110011, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);   // ecall
    gen_instr(7'b0010011, 3'd0, MT - 1, 0, 1'b0, 1'b0, 1'b0); // data on last wait
    gen_instr(7'b0010011, 3'd0, MT, 0, 1'b0, 1'b0, 1'b0);     // fetch timeout
    gen_instr(7'b0000011, 3'd2, 0, MT - 1, 1'b0, 1'b0, 1'b0); // WB data on last wait
    gen_instr(7'b0000011, 3'd2, 0, MT, 1'b0, 1'b0, 1'b0);     // WB timeout
    gen_instr(7'b0000011, 3'd2, 0, 2, 1'b0, 1'b0, 1'b1);      // reset mid-WB
    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [6:0] opc;
      opc = pick_opc($urandom_range(0, 10));
      gen_instr(opc, 3'($urandom), pick_wait(), pick_wait(), rb(), rb(),
                1'($urandom_range(0, 9) == 0));
    end

    @(posedge CLK);
    for (int k = 0; k < trace.size(); k++) begin
      #1;
      RST       = trace[k].rst;
      OPCODE    = trace[k].opc;
      FUNCT3    = trace[k].f3;
      INTR      = trace[k].intr;
      MIE       = trace[k].mie;
      MEM_VALID = trace[k].vld;
      @(negedge CLK);
      chk(trace[k].tag,
          {FAULT, RST_OUT, INT_TAKEN, CSR_WE, MEM_RDEN2, MEM_RDEN1, MEM_WE2, RF_WE, PC_WE},
          trace[k].exp);
      @(posedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
